// File: rtl/teclado_pkg.sv
// Shared types, key codes and keypad decode for the keypad BCD peripheral.
// Build option TECLADO_RETROCESO_EN is consumed by peri_teclado_bcd.
package teclado_pkg;

    typedef enum logic [1:0] {
        ESCANEO,
        REBOTE,
        PRESIONADA,
        LIBERACION
    } estado_t;

    localparam logic [3:0] TECLA_C      = 4'hC;
    localparam logic [3:0] TECLA_BORRAR = 4'hE;
    localparam logic [3:0] TECLA_ENTER  = 4'hF;
    localparam logic [3:0] MAX_DIG      = 4'd8;

    // Layout: 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D
    function automatic logic [3:0] decodifica_tecla(
        input logic [1:0] fila,
        input logic [1:0] col
    );
        logic [3:0] t;
        t = 4'h0;
        unique case ({fila, col})
            4'd0:  t = 4'h1;
            4'd1:  t = 4'h2;
            4'd2:  t = 4'h3;
            4'd3:  t = 4'hA;
            4'd4:  t = 4'h4;
            4'd5:  t = 4'h5;
            4'd6:  t = 4'h6;
            4'd7:  t = 4'hB;
            4'd8:  t = 4'h7;
            4'd9:  t = 4'h8;
            4'd10: t = 4'h9;
            4'd11: t = TECLA_C;
            4'd12: t = TECLA_BORRAR;
            4'd13: t = 4'h0;
            4'd14: t = TECLA_ENTER;
            4'd15: t = 4'hD;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/teclado_sync.sv
// Two-flop synchronizer for the asynchronous keypad rows.
// Resets to all-ones so released rows read as idle.
module teclado_sync #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] s1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1 <= '1;
            q  <= '1;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/peri_teclado_bcd.sv
// 4x4 keypad scanner with debounce, accumulating digits into packed BCD.
// Define TECLADO_RETROCESO_EN to make '*' act as backspace.
module peri_teclado_bcd
    import teclado_pkg::*;
#(
    parameter int SCAN_CYCLES     = 10000,
    parameter int DEBOUNCE_CYCLES = 200000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [3:0]  filas_i,
    output logic [3:0]  columnas_o,
    input  logic        re_i,
    output logic [31:0] data_o,
    output logic [3:0]  ndig_o,
    output logic        listo_o,
    output logic [3:0]  tecla_o,
    output logic        tecla_valida_o
);

    localparam int SW = $clog2(SCAN_CYCLES);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [SW-1:0] SCAN_FIN = SW'(SCAN_CYCLES - 1);
    localparam logic [DW-1:0] DEB_FIN  = DW'(DEBOUNCE_CYCLES - 1);

    logic [3:0]    f;
    estado_t       estado, estado_n;
    logic [1:0]    col, col_n;
    logic [1:0]    fila, fila_n;
    logic [SW-1:0] cnt_s, cnt_s_n;
    logic [DW-1:0] cnt_d, cnt_d_n;
    logic          acepta;
    logic [1:0]    fila_baja;
    logic [3:0]    tecla_cod;
    logic [31:0]   data_n;
    logic [3:0]    ndig_n;
    logic          listo_n;
    logic [3:0]    tecla_n;

    teclado_sync #(.W(4)) u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d     (filas_i),
        .q     (f)
    );

    assign columnas_o = ~(4'b0001 << col);
    assign tecla_cod  = decodifica_tecla(fila, col);

    // Lowest-index low row wins.
    always_comb begin
        fila_baja = 2'd3;
        if (!f[2]) fila_baja = 2'd2;
        if (!f[1]) fila_baja = 2'd1;
        if (!f[0]) fila_baja = 2'd0;
    end

    always_comb begin
        estado_n = estado;
        col_n    = col;
        fila_n   = fila;
        cnt_s_n  = cnt_s;
        cnt_d_n  = cnt_d;
        acepta   = 1'b0;
        unique case (estado)
            ESCANEO: begin
                if (cnt_s == SCAN_FIN) begin
                    cnt_s_n = '0;
                    if (f != 4'hF) begin
                        fila_n   = fila_baja;
                        cnt_d_n  = '0;
                        estado_n = REBOTE;
                    end else begin
                        col_n = col + 2'd1;
                    end
                end else begin
                    cnt_s_n = cnt_s + SW'(1);
                end
            end
            REBOTE: begin
                if (f[fila]) begin
                    estado_n = ESCANEO;
                    col_n    = col + 2'd1;
                    cnt_d_n  = '0;
                    cnt_s_n  = '0;
                end else if (cnt_d == DEB_FIN) begin
                    acepta   = 1'b1;
                    cnt_d_n  = '0;
                    estado_n = PRESIONADA;
                end else begin
                    cnt_d_n = cnt_d + DW'(1);
                end
            end
            PRESIONADA: begin
                if (f == 4'hF) begin
                    cnt_d_n  = '0;
                    estado_n = LIBERACION;
                end
            end
            LIBERACION: begin
                if (f != 4'hF) begin
                    cnt_d_n = '0;
                end else if (cnt_d == DEB_FIN) begin
                    estado_n = ESCANEO;
                    col_n    = col + 2'd1;
                    cnt_d_n  = '0;
                    cnt_s_n  = '0;
                end else begin
                    cnt_d_n = cnt_d + DW'(1);
                end
            end
            default: estado_n = ESCANEO;
        endcase
    end

    // A read acknowledge overrides the data effect of a same-edge key.
    always_comb begin
        data_n  = data_o;
        ndig_n  = ndig_o;
        listo_n = listo_o;
        tecla_n = acepta ? tecla_cod : tecla_o;
        if (re_i) begin
            data_n  = '0;
            ndig_n  = '0;
            listo_n = 1'b0;
        end else if (acepta) begin
            if (tecla_cod == TECLA_C) begin
                data_n  = '0;
                ndig_n  = '0;
                listo_n = 1'b0;
            end else if (tecla_cod == TECLA_ENTER) begin
                listo_n = 1'b1;
            end else if (!listo_o) begin
                if (tecla_cod <= 4'd9) begin
                    if (ndig_o < MAX_DIG) begin
                        data_n = {data_o[27:0], tecla_cod};
                        ndig_n = ndig_o + 4'd1;
                    end
                end
`ifdef TECLADO_RETROCESO_EN
                else if (tecla_cod == TECLA_BORRAR && ndig_o != 4'd0) begin
                    data_n = data_o >> 4;
                    ndig_n = ndig_o - 4'd1;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            estado         <= ESCANEO;
            col            <= '0;
            fila           <= '0;
            cnt_s          <= '0;
            cnt_d          <= '0;
            data_o         <= '0;
            ndig_o         <= '0;
            listo_o        <= 1'b0;
            tecla_o        <= '0;
            tecla_valida_o <= 1'b0;
        end else begin
            estado         <= estado_n;
            col            <= col_n;
            fila           <= fila_n;
            cnt_s          <= cnt_s_n;
            cnt_d          <= cnt_d_n;
            data_o         <= data_n;
            ndig_o         <= ndig_n;
            listo_o        <= listo_n;
            tecla_o        <= tecla_n;
            tecla_valida_o <= acepta;
        end
    end

endmodule

// File: tb/tb_peri_teclado_bcd.sv
// Bench for peri_teclado_bcd: keypad model plus digit-queue reference.
// Honours TECLADO_RETROCESO_EN the same way as the design.
module tb_peri_teclado_bcd;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  filas;
    logic [3:0]  columnas;
    logic        re = 1'b0;
    logic [31:0] data;
    logic [3:0]  ndig;
    logic        listo;
    logic [3:0]  tecla;
    logic        valida;

    peri_teclado_bcd #(
        .SCAN_CYCLES     (4),
        .DEBOUNCE_CYCLES (8)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .filas_i        (filas),
        .columnas_o     (columnas),
        .re_i           (re),
        .data_o         (data),
        .ndig_o         (ndig),
        .listo_o        (listo),
        .tecla_o        (tecla),
        .tecla_valida_o (valida)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    logic [3:0] codes [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                               4'h4, 4'h5, 4'h6, 4'hB,
                               4'h7, 4'h8, 4'h9, 4'hC,
                               4'hE, 4'h0, 4'hF, 4'hD};

    logic       pressed = 1'b0;
    logic [1:0] prow = '0;
    logic [1:0] pcol = '0;
    logic [3:0] exp_code = '0;

    always_comb begin
        filas = 4'hF;
        if (pressed && !columnas[pcol]) filas[prow] = 1'b0;
    end

    // Reference: queue of entered digits, newest at the back.
    int unsigned mq[$];
    logic m_listo = 1'b0;
    logic activo = 1'b0;
    logic re_seen = 1'b0;
    logic rst_seen = 1'b1;
    int pulses = 0;
    logic coincide = 1'b0;

    always @(posedge clk) begin
        re_seen  <= re;
        rst_seen <= rst;
    end

    function automatic logic [31:0] m_data();
        logic [31:0] d;
        d = '0;
        foreach (mq[i]) d = (d << 4) | 32'(mq[i]);
        return d;
    endfunction

    task automatic aplica(input logic [3:0] c);
        if (c == 4'hC) begin
            mq.delete();
            m_listo = 1'b0;
        end else if (c == 4'hF) begin
            m_listo = 1'b1;
        end else if (c == 4'hE) begin
`ifdef TECLADO_RETROCESO_EN
            if (!m_listo && mq.size() > 0) void'(mq.pop_back());
`endif
        end else if (c <= 4'd9 && !m_listo && mq.size() < 8) begin
            mq.push_back(32'(c));
        end
    endtask

    always @(negedge clk) begin
        if (activo) begin
            if (rst_seen) begin
                mq.delete();
                m_listo = 1'b0;
            end else begin
                if (valida) begin
                    pulses++;
                    chk("tecla", 32'(tecla), 32'(exp_code));
                    if (re_seen) coincide = 1'b1;
                end
                if (re_seen) begin
                    mq.delete();
                    m_listo = 1'b0;
                end else if (valida) begin
                    aplica(exp_code);
                end
            end
            chk("data", data, m_data());
            chk("ndig", 32'(ndig), 32'(mq.size()));
            chk("listo", 32'(listo), 32'(m_listo));
        end
    end

    task automatic set_key(input logic [3:0] c);
        for (int i = 0; i < 16; i++)
            if (codes[i] == c) begin
                prow = 2'(i / 4);
                pcol = 2'(i % 4);
            end
        exp_code = c;
    endtask

    function automatic logic [3:0] tgt();
        return ~(4'b0001 << pcol);
    endfunction

    task automatic off_target();
        int n;
        n = 0;
        while (columnas == tgt() && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Press until the scanner parks on our column for `run` samples.
    task automatic press_until_run(input int run);
        int r, n;
        off_target();
        pressed = 1'b1;
        r = 0;
        n = 0;
        while (r < run && n < 300) begin
            @(negedge clk);
            n++;
            if (columnas == tgt()) r++;
            else r = 0;
        end
        if (n >= 300) chk("run_timeout", 32'(n), 32'd0);
    endtask

    task automatic wait_pulse(input int p0);
        int n;
        n = 0;
        while (pulses == p0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (pulses == p0) chk("pulse_timeout", 32'(n), 32'd0);
    endtask

    task automatic release_key();
        pressed = 1'b0;
        repeat (40) @(negedge clk);
    endtask

    task automatic press(input logic [3:0] c, input int hold);
        int p0;
        set_key(c);
        p0 = pulses;
        pressed = 1'b1;
        wait_pulse(p0);
        repeat (hold) @(negedge clk);
        release_key();
        chk("one_pulse", 32'(pulses - p0), 32'd1);
    endtask

    task automatic pulse_re();
        re = 1'b1;
        @(negedge clk);
        re = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int p0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_col", 32'(columnas), 32'h0000000E);
        chk("rst_data", data, 32'h0);
        chk("rst_ndig", 32'(ndig), 32'd0);
        chk("rst_listo", 32'(listo), 32'd0);
        chk("rst_tecla", 32'(tecla), 32'd0);
        chk("rst_valida", 32'(valida), 32'd0);
        activo = 1'b1;

        press(4'h1, 3);
        press(4'h2, 5);
        press(4'h3, 2);
        press(4'h4, 7);
        press(4'hF, 4);
        chk("t1_data", data, 32'h1234);
        chk("t1_ndig", 32'(ndig), 32'd4);
        chk("t1_listo", 32'(listo), 32'd1);
        pulse_re();
        chk("t1_re_data", data, 32'h0);
        chk("t1_re_listo", 32'(listo), 32'd0);

        press(4'h6, 2);
        set_key(4'h5);
        p0 = pulses;
        press_until_run(6);
        release_key();
        repeat (20) @(negedge clk);
        chk("t2_abort", 32'(pulses - p0), 32'd0);
        chk("t2_data", data, 32'h6);
        set_key(4'h8);
        repeat ($urandom_range(0, 7)) @(negedge clk);
        p0 = pulses;
        pressed = 1'b1;
        repeat (3) @(negedge clk);
        release_key();
        chk("t2_glitch", 32'(pulses - p0), 32'd0);
        press(4'h2, 500);

        press(4'hC, 1);
        for (int i = 0; i < 9; i++) press(4'h9, 1);
        chk("t3_data", data, 32'h99999999);
        chk("t3_ndig", 32'(ndig), 32'd8);

        press(4'hC, 1);
        press(4'h5, 1);
        press(4'h6, 1);
        press(4'h7, 1);
        press(4'hE, 1);
`ifdef TECLADO_RETROCESO_EN
        chk("t4_data", data, 32'h56);
        chk("t4_ndig", 32'(ndig), 32'd2);
`else
        chk("t4_data", data, 32'h567);
        chk("t4_ndig", 32'(ndig), 32'd3);
`endif
        press(4'hC, 1);
        press(4'hE, 1);
        chk("t4_empty", data, 32'h0);

        press(4'h8, 1);
        press(4'hF, 1);
        press(4'h3, 1);
        chk("t5_data", data, 32'h8);
        press(4'hC, 1);
        chk("t5_c_data", data, 32'h0);
        chk("t5_c_listo", 32'(listo), 32'd0);
        press(4'h2, 1);
        set_key(4'h5);
        coincide = 1'b0;
        p0 = pulses;
        press_until_run(12);
        re = 1'b1;
        @(negedge clk);
        re = 1'b0;
        wait_pulse(p0);
        release_key();
        chk("t5_coincide", 32'(coincide), 32'd1);
        chk("t5_pulse", 32'(pulses - p0), 32'd1);
        chk("t5_data0", data, 32'h0);

        press(4'h7, 1);
        set_key(4'h4);
        press_until_run(6);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_col", 32'(columnas), 32'h0000000E);
        chk("t6_data", data, 32'h0);
        chk("t6_ndig", 32'(ndig), 32'd0);
        chk("t6_tecla", 32'(tecla), 32'd0);
        chk("t6_valida", 32'(valida), 32'd0);
        p0 = pulses;
        wait_pulse(p0);
        repeat (5) @(negedge clk);
        release_key();
        chk("t6_again", 32'(pulses - p0), 32'd1);
        chk("t6_digit", data, 32'h4);

        for (int i = 0; i < 16; i++) begin
            press(4'($urandom_range(0, 15)), $urandom_range(1, 20));
            if ($urandom_range(0, 3) == 0) pulse_re();
        end

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
